x_mult_pe: RTL
==============

Name: x_mult_pe

Overview:
Per-multiplier processing element on the X bus, directly downstream of the Y-row multicast stage.
- Captures X-bus transfers whose tag_x matches its own x_id and buffers them in a small operand FIFO.
- Multiplies each buffered operand by a stationary weight and accumulates acc_len products.
- Presents the resulting partial sum on a valid/ready output port.
- Backpressures the X bus through to_Xbus_ready.

Parameters:
- DATA_W, 32, X-bus value width; operand is value[15:0], signed.
- ID_W, 9, width of x_id and tag_x.
- FIFO_DEPTH, 4, operand FIFO entries; power of two, at least 2.
- ACC_W, 40, signed accumulator and psum width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- x_id  in  ID_W  column id of this PE.
- from_Xbus_enable  in  1  X-bus transfer strobe.
- from_Xbus_tag_x  in  ID_W  destination column tag.
- from_Xbus_value  in  DATA_W  transfer payload.
- to_Xbus_ready  out  1  FIFO can accept an operand.
- weight_load  in  1  load-weight strobe.
- weight_value  in  16  signed stationary weight.
- acc_len  in  8  products per psum; 0 is treated as 1.
- psum_valid  out  1  psum available.
- psum_ready  in  1  consumer accepts psum.
- psum_data  out  ACC_W  accumulated partial sum.
- busy  out  1  PE is not in IDLE, or FIFO/pipeline is non-empty.

Behaviour:
- Asynchronous reset: FIFO empty, weight 0, accumulator 0, count 0, state IDLE, x_id register 0.
- Output values in reset: psum_valid 0, psum_data 0, busy 0, to_Xbus_ready 1.
- x_id is registered every cycle (x_id_q). All matching uses x_id_q.
- to_Xbus_ready = !fifo_full. It is derived from the registered occupancy count, with no combinational path from enable.
- push = from_Xbus_enable && (from_Xbus_tag_x == x_id_q) && to_Xbus_ready.
  - A non-matching or not-ready transfer is dropped silently.
  - The upstream stage guarantees enable is only asserted while it sees ready.
- Simultaneous push and pop on a full FIFO is allowed; occupancy is unchanged. Pointers wrap modulo FIFO_DEPTH.
- Pipeline:
  - S0: pop when FIFO non-empty and state is IDLE or ACCUM.
  - S1: product register = signed(op[15:0]) * signed(weight), 32 bits, with valid bit.
  - S2: acc += sign-extended product.
- Latency: operand pushed at edge T; popped at T+1; product registered at T+2; accumulated at T+3. With acc_len=1, psum_valid is high in the cycle after edge T+4.
- FSM:
  - IDLE: on first pop, latch len = max(acc_len,1), clear acc, count=1. If len==1 go to WAIT, else go to ACCUM.
  - ACCUM: each pop increments count. When count reaches len, go to WAIT. No further pops in WAIT.
  - WAIT: when S1 and S2 are empty (last product accumulated), go to OUT.
  - OUT: psum_valid=1, psum_data=acc, held stable until psum_ready. On handshake, clear acc and go to IDLE.
  - A pop in the same cycle as the OUT→IDLE handshake is not allowed; the next group starts the following cycle.
- While in WAIT or OUT, pops stall, the FIFO fills and ready deasserts. Nothing is lost.
- weight_load takes effect only when !busy. It is ignored otherwise, and the weight is unchanged.
- acc_len changes mid-group have no effect; len is latched at group start.
- Arithmetic wraps modulo 2^ACC_W unless saturation is enabled.
- rst asserted mid-group aborts the group: FIFO contents and acc are discarded and no psum is emitted.

Optional Feature:
- Macro: X_MULT_PE_PSUM_SAT_EN.
- Defined: S2 saturates acc to [-2^(ACC_W-1), 2^(ACC_W-1)-1] on overflow. A sticky psum_sat flag is emitted with psum_data (extra output port) and cleared on the psum handshake.
- Undefined: two's-complement wrap, and no psum_sat port.

Decomposition:
- Package x_mult_pkg holds:
  - typedef enum pe_state_t {IDLE, ACCUM, WAIT, OUT}.
  - localparams OP_W=16 and PROD_W=32.
  - a function sat_add for the optional feature.
- Sub-module x_operand_fifo (parameterised DATA width = OP_W, DEPTH = FIFO_DEPTH).
  - Ports: push, pop, din, dout, full, empty, count.
  - Synchronous FIFO with registered occupancy, async active-low reset.

Test Plan:
1. x_id=5, weight=3, acc_len=4; push values 1,2,3,4 with tag_x=5 → single psum 30, psum_valid 4 cycles after the last push; busy drops after the handshake.
2. Transfers with tag_x=6 while x_id=5 → no push, FIFO stays empty, psum_valid never asserts, to_Xbus_ready stays 1.
3. psum_ready held 0 in OUT; push 5 operands with FIFO_DEPTH=4 → ready deasserts after 4 pushes, 5th is blocked upstream; after psum_ready the queued 4 form the next group, with no loss.
4. acc_len=0, weight=-2, push 7 → psum -14. Then weight_load=10 asserted while busy → ignored, next group still uses -2.
5. Push 2 of 4 operands, assert rst for 1 cycle → psum_valid 0, ready 1, busy 0. A fresh group of 4 ones with weight 1 → psum 4.
6. With X_MULT_PE_PSUM_SAT_EN, ACC_W=40: operands 0x7FFF, weight 0x7FFF, acc_len=255 → psum is the true sum 255*0x3FFF0001 (no overflow), psum_sat=0. Force overflow via repeated groups without clear (a bench-only override) → clamps to 2^39-1 with psum_sat=1. Without the macro, the wrapped value is checked.

Source files
------------

// File: rtl/x_mult_pkg.sv
// Shared types and constants for the X-bus multiplier PE.
// sat_add is only referenced when X_MULT_PE_PSUM_SAT_EN is defined.
package x_mult_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, WAIT, OUT} pe_state_t;

  localparam int OP_W   = 16;
  localparam int PROD_W = 32;

  // Signed add clamped to the range of a w-bit two's-complement value (w <= 63).
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int                 w);
    logic signed [63:0] s, hi, lo;
    s  = a + b;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (s > hi)      sat_add = hi;
    else if (s < lo) sat_add = lo;
    else             sat_add = s;
  endfunction

endpackage

// File: rtl/x_operand_fifo.sv
// Synchronous operand FIFO with registered occupancy count and async active-low reset.
// DEPTH must be a power of two; pointers wrap naturally.
module x_operand_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        din,
  output logic [DATA_W-1:0]        dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic              push_ok, pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  // A push into a full FIFO is legal only when the same cycle frees a slot.
  assign push_ok = push && (!full || pop_ok);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/x_mult_pe.sv
// X-bus multiplier PE: tag-filtered operand FIFO, stationary-weight multiply, acc_len-product psum.
// Define X_MULT_PE_PSUM_SAT_EN for a saturating accumulator with a sticky psum_sat output.
//   state | meaning
//   IDLE  | waiting for the first operand of a group
//   ACCUM | popping the remaining operands of the group
//   WAIT  | all operands popped, draining multiply/accumulate pipeline
//   OUT   | psum presented until psum_ready
module x_mult_pe
  import x_mult_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ID_W       = 9,
  parameter int FIFO_DEPTH = 4,
  parameter int ACC_W      = 40
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ID_W-1:0]   x_id,
  input  logic              from_Xbus_enable,
  input  logic [ID_W-1:0]   from_Xbus_tag_x,
  input  logic [DATA_W-1:0] from_Xbus_value,
  output logic              to_Xbus_ready,
  input  logic              weight_load,
  input  logic [15:0]       weight_value,
  input  logic [7:0]        acc_len,
  output logic              psum_valid,
  input  logic              psum_ready,
  output logic [ACC_W-1:0]  psum_data,
  output logic              busy
`ifdef X_MULT_PE_PSUM_SAT_EN
  ,
  output logic              psum_sat
`endif
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  pe_state_t                state_q, state_d;
  logic [ID_W-1:0]          x_id_q;
  logic signed [OP_W-1:0]   weight_q, op_q;
  logic signed [PROD_W-1:0] prod_q;
  logic signed [ACC_W-1:0]  acc_q, acc_next, prod_ext;
  logic                     op_v, prod_v;
  logic                     push, pop, grp_start, psum_take;
  logic                     fifo_full, fifo_empty;
  logic [OP_W-1:0]          fifo_dout;
  logic [CNT_W-1:0]         fifo_count;
  logic [7:0]               len_q, cnt_q;
  logic                     unused_value_hi;

  assign unused_value_hi = ^from_Xbus_value[DATA_W-1:OP_W];

  assign to_Xbus_ready = !fifo_full;
  assign push = from_Xbus_enable && (from_Xbus_tag_x == x_id_q) && to_Xbus_ready;
  assign busy = (state_q != IDLE) || (fifo_count != '0) || op_v || prod_v;
  assign psum_data = psum_valid ? acc_q : '0;

  x_operand_fifo #(
    .DATA_W (OP_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (from_Xbus_value[OP_W-1:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    grp_start  = 1'b0;
    psum_valid = 1'b0;
    psum_take  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          grp_start = 1'b1;
          state_d   = (acc_len <= 8'd1) ? WAIT : ACCUM;
        end
      end
      ACCUM: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (cnt_q + 8'd1 == len_q) state_d = WAIT;
        end
      end
      WAIT: begin
        if (!op_v && !prod_v) state_d = OUT;
      end
      OUT: begin
        psum_valid = 1'b1;
        if (psum_ready) begin
          psum_take = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef X_MULT_PE_PSUM_SAT_EN
  logic signed [63:0] sum_sat;
  logic               acc_ovf;

  always_comb begin
    prod_ext = ACC_W'(prod_q);
    sum_sat  = sat_add(64'(acc_q), 64'(prod_ext), ACC_W);
    acc_next = sum_sat[ACC_W-1:0];
    acc_ovf  = (sum_sat != (64'(acc_q) + 64'(prod_ext)));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   psum_sat <= 1'b0;
    else if (psum_take)         psum_sat <= 1'b0;
    else if (prod_v && acc_ovf) psum_sat <= 1'b1;
  end
`else
  always_comb begin
    prod_ext = ACC_W'(prod_q);
    acc_next = acc_q + prod_ext;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      x_id_q   <= '0;
      weight_q <= '0;
      op_q     <= '0;
      op_v     <= 1'b0;
      prod_q   <= '0;
      prod_v   <= 1'b0;
      acc_q    <= '0;
      len_q    <= 8'd1;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      x_id_q  <= x_id;
      if (weight_load && !busy) weight_q <= weight_value;
      op_v   <= pop;
      if (pop) op_q <= fifo_dout;
      prod_v <= op_v;
      if (op_v) prod_q <= PROD_W'(op_q) * PROD_W'(weight_q);
      if (grp_start) begin
        len_q <= (acc_len == 8'd0) ? 8'd1 : acc_len;
        cnt_q <= 8'd1;
      end else if (pop) begin
        cnt_q <= cnt_q + 8'd1;
      end
      if (grp_start || psum_take) acc_q <= '0;
      else if (prod_v)            acc_q <= acc_next;
    end
  end

endmodule
